mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that shares the CPU's single byte-wide RAM port between instruction fetch (IF) and data access (MEM stage). It arbitrates the two 32-bit requesters, splits each word/half/byte access into sequential byte transactions, and reassembles read data little-endian. It sits between the pipeline top and the external RAM, replacing the direct ROM connection.

## Interface
- ADDR_W, 32, byte address width on all address ports
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch byte address, stable while if_req
- if_data  out  32  fetched word, valid while if_done
- if_done  out  1  one-cycle completion pulse for fetch
- mem_req  in  1  data request, level, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_addr  in  ADDR_W  data byte address
- mem_wdata  in  32  store data, low bytes used per mem_len
- mem_rdata  out  32  load data, zero-extended, valid while mem_done
- mem_done  out  1  one-cycle completion pulse for data access
- ram_din  in  8  RAM read byte, one cycle after address
- ram_dout  out  8  RAM write byte
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: if mem_req → latch addr/len/wdata/we, owner=MEM, go RD or WR; else if if_req → owner=IF, len=word, go RD; else stay. MEM has strict priority on a simultaneous request.
- N = bytes per access (1, 2, 4). Byte counter k starts at 0.
- RD: cycle k, 0 ≤ k < N: ram_addr = base+k, ram_wr=0. Cycle k ≥ 1: capture ram_din into byte k-1 of buffer. Runs N+1 cycles, then DONE.
- WR: cycle k, 0 ≤ k < N: ram_wr=1, ram_addr = base+k, ram_dout = wdata[8k+7:8k]. Runs N cycles, then DONE.
- DONE: one cycle; assert owner's done; drive buffer on if_data/mem_rdata; no request accepted; then IDLE. Requesters deassert or change req at the edge ending DONE.
- Address arithmetic modulo 2^ADDR_W (base+k wraps past all-ones). No alignment check.
- Load data zero-extended above N bytes; sign extension belongs to the MEM stage. Stores report mem_rdata = 0.
- Requests deasserted mid-access are ignored; the latched access completes.

## Timing
- Reset (rst=0): state IDLE, all outputs 0 immediately (ram_wr drops asynchronously); in-flight access aborted, no done pulse.
- Latency, request seen in IDLE at cycle 0: word read done at cycle 6; half read cycle 4; byte read cycle 3; word write cycle 5; half write cycle 3; byte write cycle 2.
- Back-to-back: minimum one IDLE cycle between DONE and next accept; next access RAM traffic begins the cycle after that IDLE.
- IDLE/DONE outputs: ram_wr=0, ram_addr=0, ram_dout=0. Done outputs registered; data outputs held only during DONE, 0 otherwise.
- A pending IF request waits behind any number of MEM requests (no fairness guarantee; MEM issues at most one per instruction).

## Structure
- Shared package (defines): state encoding, mem_len codes (LEN_B/LEN_H/LEN_W), owner codes, RAM data width 8.
- Single module; arbiter, byte counter and assembly buffer inline. No sub-module.

## Test plan
- Reset mid-word-write (assert rst at WR k=2) → ram_wr=0 that cycle, busy=0, no mem_done, next access clean.
- IF word read at 0x1000, RAM bytes 0x13,0x05,0x10,0x00 → if_done at cycle 6, if_data=0x00100513, ram_addr 0x1000..0x1003 in cycles 1-4.
- Simultaneous if_req(0x2000) and mem_req load byte 0x3001 (RAM 0xFF) → mem_done cycle 3, mem_rdata=0x000000FF; IF accepted cycle 5 after IDLE, if_done cycle 11.
- Store half 0xABCD1234 at 0x40 → ram_wr cycles 1-2, (0x40,0x34),(0x41,0x12); mem_done cycle 3; 0x42 untouched.
- Word read at 0xFFFFFFFE → ram_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; bytes assembled little-endian.
- Requester holds if_req through DONE and drops after → exactly one access, one if_done pulse, busy=0 afterwards.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// access-length codes, requester owner codes and the RAM data width.
package mem_ctrl_pkg;

  localparam int RAM_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Code 2'b11 is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising word/half/byte accesses and reassembling reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic [RAM_W-1:0]  ram_din,
  output logic [RAM_W-1:0]  ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              busy,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  owner_e            owner_q, owner_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic              hold_q, hold_d;

  logic [31:0]       if_data_q, if_data_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;
  logic [RAM_W-1:0]  ram_dout_q, ram_dout_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic              busy_q, busy_d;

  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] byte_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    base_d  = base_q;
    we_d    = we_q;
    owner_d = owner_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    hold_d  = 1'b0;
    // RAM data lags the address by one cycle, so cycle k fills byte k-1.
    cap_idx = cnt_q[1:0] - 2'd1;

    case (state_q)
      S_IDLE: begin
        // hold_q forces one non-accepting IDLE cycle after every DONE.
        if (!hold_q) begin
          if (mem_req) begin
            base_d  = mem_addr;
            n_d     = len_bytes(mem_len);
            we_d    = mem_we;
            wdata_d = mem_wdata;
            owner_d = OWN_MEM;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = mem_we ? S_WR : S_RD;
          end else if (if_req) begin
            base_d  = if_addr;
            n_d     = len_bytes(LEN_W);
            we_d    = 1'b0;
            wdata_d = 32'd0;
            owner_d = OWN_IF;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q != 3'd0) buf_d[{cap_idx, 3'b000} +: 8] = ram_din;
        if (cnt_q == n_q) state_d = S_DONE;
        else              cnt_d   = cnt_q + 3'd1;
      end
      S_WR: begin
        if (cnt_q == n_q - 3'd1) state_d = S_DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        hold_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops aligned to it.
  always_comb begin
    if_data_d   = 32'd0;
    if_done_d   = 1'b0;
    mem_rdata_d = 32'd0;
    mem_done_d  = 1'b0;
    ram_dout_d  = '0;
    ram_addr_d  = '0;
    ram_wr_d    = 1'b0;
    busy_d      = (state_d != S_IDLE);
    byte_addr   = base_d + {{(ADDR_W-3){1'b0}}, cnt_d};

    case (state_d)
      S_RD: begin
        if (cnt_d < n_d) ram_addr_d = byte_addr;
      end
      S_WR: begin
        ram_wr_d   = 1'b1;
        ram_addr_d = byte_addr;
        ram_dout_d = wdata_d[{cnt_d[1:0], 3'b000} +: 8];
      end
      S_DONE: begin
        if (owner_d == OWN_IF) begin
          if_done_d = 1'b1;
          if_data_d = buf_d;
        end else begin
          mem_done_d  = 1'b1;
          mem_rdata_d = we_d ? 32'd0 : buf_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      we_q        <= 1'b0;
      owner_q     <= OWN_IF;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      hold_q      <= 1'b0;
      if_data_q   <= 32'd0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= 32'd0;
      mem_done_q  <= 1'b0;
      ram_dout_q  <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      hold_q      <= hold_d;
      if_data_q   <= if_data_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      ram_dout_q  <= ram_dout_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      busy_q      <= busy_d;
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_dout  = ram_dout_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model on the RAM port, a separate reference
// memory for expected data, scenario tasks plus randomized accesses.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [7:0]  ram_din = 8'h00;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        busy;
  logic [1:0]  dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] exp_q[$];

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
    if (ram_wr) ram[ram_addr] = ram_dout;
    ram_din <= rd;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers (stimulus / reference) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  function automatic int n_bytes(input logic [1:0] len);
    if (len == 2'b00) return 1;
    if (len == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ai = a + 32'(i);
      logic [31:0] b  = ref_mem.exists(ai) ? {24'd0, ref_mem[ai]} : 32'd0;
      v = v | (b << (8 * i));
    end
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = 8'(d >> (8 * i));
  endtask

  // One full access from a quiet IDLE; checks traffic, latency and data.
  task automatic do_access(input bit is_mem, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input string name);
    int n, exp_lat, cyc;
    logic [31:0] exp_d, got_d;
    bit seen;
    n       = n_bytes(len);
    exp_lat = we ? n + 1 : n + 2;
    exp_q.push_back(we ? 32'd0 : ref_read(addr, n));
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    seen = 1'b0;
    got_d = 32'd0;
    cyc = 0;
    while (cyc < 20 && !seen) begin
      tick();
      cyc++;
      if (cyc <= n) begin
        logic [31:0] ea = addr + 32'(cyc - 1);
        total_cnt++;
        if (ram_addr !== ea) $display("FAIL %s ram_addr cyc %0d: got %h exp %h", name, cyc, ram_addr, ea);
        else pass_cnt++;
        total_cnt++;
        if (ram_wr !== we) $display("FAIL %s ram_wr cyc %0d: got %b exp %b", name, cyc, ram_wr, we);
        else pass_cnt++;
        if (we) begin
          logic [7:0] eb = 8'(wdata >> (8 * (cyc - 1)));
          total_cnt++;
          if (ram_dout !== eb) $display("FAIL %s ram_dout cyc %0d: got %h exp %h", name, cyc, ram_dout, eb);
          else pass_cnt++;
        end
      end
      if ((is_mem ? mem_done : if_done) === 1'b1) begin
        seen  = 1'b1;
        got_d = is_mem ? mem_rdata : if_data;
      end
    end
    total_cnt++;
    if (!seen || cyc != exp_lat) $display("FAIL %s latency: got %0d exp %0d (done seen %b)", name, cyc, exp_lat, seen);
    else pass_cnt++;
    exp_d = exp_q.pop_front();
    total_cnt++;
    if (got_d !== exp_d) $display("FAIL %s data: got %h exp %h", name, got_d, exp_d);
    else pass_cnt++;
    if (we) ref_write(addr, wdata, n);
    mem_req = 1'b0;
    if_req  = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || if_done !== 1'b0 || mem_done !== 1'b0 || if_data !== 32'd0 || mem_rdata !== 32'd0)
      $display("FAIL %s after-done idle: busy %b if_done %b mem_done %b if_data %h mem_rdata %h exp all 0",
               name, busy, if_done, mem_done, if_data, mem_rdata);
    else pass_cnt++;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 32'd0 || ram_dout !== 8'd0)
      $display("FAIL reset ram side: busy %b ram_wr %b ram_addr %h ram_dout %h exp all 0", busy, ram_wr, ram_addr, ram_dout);
    else pass_cnt++;
    total_cnt++;
    if (if_done !== 1'b0 || mem_done !== 1'b0 || if_data !== 32'd0 || mem_rdata !== 32'd0)
      $display("FAIL reset cpu side: if_done %b mem_done %b if_data %h mem_rdata %h exp all 0", if_done, mem_done, if_data, mem_rdata);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 2'd0) $display("FAIL reset state: got %0d exp 0", dbg_state);
    else pass_cnt++;
    rst = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_mid_write();
    int done_cnt = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h80; mem_wdata = 32'hDEADBEEF;
    tick(); tick(); tick();
    total_cnt++;
    if (ram_wr !== 1'b1 || ram_addr !== 32'h82) $display("FAIL midwr k2 strobe: got wr %b addr %h exp 1 00000082", ram_wr, ram_addr);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (ram_wr !== 1'b0 || busy !== 1'b0 || ram_addr !== 32'd0)
      $display("FAIL midwr async reset: wr %b busy %b addr %h exp 0 0 0", ram_wr, busy, ram_addr);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_done === 1'b1) done_cnt++;
    end
    total_cnt++;
    if (done_cnt != 0) $display("FAIL midwr done pulse: got %0d pulses exp 0", done_cnt);
    else pass_cnt++;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rst = 1'b1;
    tick(); tick();
    // Bytes 0 and 1 reached RAM before the reset; byte 2 did not.
    ref_write(32'h80, 32'h0000BEEF, 2);
    do_access(1'b1, 1'b0, 2'b10, 32'h80, 32'd0, "midwr_reload");
  endtask

  task automatic test_if_fetch();
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h10); poke(32'h1003, 8'h00);
    total_cnt++;
    if (ref_read(32'h1000, 4) !== 32'h00100513) $display("FAIL fetch ref setup: got %h exp 00100513", ref_read(32'h1000, 4));
    else pass_cnt++;
    do_access(1'b0, 1'b0, 2'b10, 32'h1000, 32'd0, "if_fetch");
  endtask

  task automatic test_simultaneous();
    int cyc = 0, md_cyc = 0, if_cyc = 0, first_if = 0, md_cnt = 0;
    logic [31:0] md_data = 32'd0, if_d = 32'd0, exp_if;
    poke(32'h3001, 8'hFF);
    for (int i = 0; i < 4; i++) poke(32'h2000 + 32'(i), 8'($urandom_range(0, 255)));
    exp_if = ref_read(32'h2000, 4);
    if_req = 1'b1; if_addr = 32'h2000;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h3001;
    while (cyc < 30 && if_cyc == 0) begin
      tick();
      cyc++;
      if (mem_done === 1'b1) begin
        md_cnt++;
        md_cyc  = cyc;
        md_data = mem_rdata;
        mem_req = 1'b0;
      end
      if (ram_addr === 32'h2000 && first_if == 0) first_if = cyc;
      if (if_done === 1'b1) begin
        if_cyc = cyc;
        if_d   = if_data;
      end
    end
    total_cnt++;
    if (md_cyc != 3 || md_cnt != 1) $display("FAIL simul mem_done: got cycle %0d count %0d exp 3 1", md_cyc, md_cnt);
    else pass_cnt++;
    total_cnt++;
    if (md_data !== 32'h000000FF) $display("FAIL simul mem_rdata: got %h exp 000000ff", md_data);
    else pass_cnt++;
    total_cnt++;
    if (first_if != 6) $display("FAIL simul if traffic start: got cycle %0d exp 6", first_if);
    else pass_cnt++;
    total_cnt++;
    if (if_cyc != 11) $display("FAIL simul if_done: got cycle %0d exp 11", if_cyc);
    else pass_cnt++;
    total_cnt++;
    if (if_d !== exp_if) $display("FAIL simul if_data: got %h exp %h", if_d, exp_if);
    else pass_cnt++;
    if_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_store_half();
    poke(32'h42, 8'h77);
    do_access(1'b1, 1'b1, 2'b01, 32'h40, 32'hABCD1234, "store_half");
    total_cnt++;
    if (ram[32'h42] !== 8'h77) $display("FAIL store_half untouched 0x42: got %h exp 77", ram[32'h42]);
    else pass_cnt++;
    do_access(1'b1, 1'b0, 2'b01, 32'h41, 32'd0, "store_half_readback");
  endtask

  task automatic test_wrap();
    poke(32'hFFFFFFFE, 8'hA1); poke(32'hFFFFFFFF, 8'hB2); poke(32'h0, 8'hC3); poke(32'h1, 8'hD4);
    do_access(1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'd0, "wrap_word");
    do_access(1'b0, 1'b0, 2'b10, 32'hFFFFFFFF, 32'd0, "wrap_fetch");
  endtask

  task automatic test_hold_through_done();
    int cyc = 0, done_cyc = 0, extra = 0;
    if_req = 1'b1; if_addr = 32'h1000;
    while (cyc < 20 && done_cyc == 0) begin
      tick();
      cyc++;
      if (if_done === 1'b1) done_cyc = cyc;
    end
    tick();
    if_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if_done === 1'b1) extra++;
      tick();
    end
    total_cnt++;
    if (done_cyc != 6) $display("FAIL hold if_done: got cycle %0d exp 6", done_cyc);
    else pass_cnt++;
    total_cnt++;
    if (extra != 0 || busy !== 1'b0) $display("FAIL hold extra access: got %0d pulses busy %b exp 0 0", extra, busy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      bit          is_mem = 1'($urandom_range(0, 1));
      bit          we     = is_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      logic [1:0]  len    = is_mem ? 2'($urandom_range(0, 3)) : 2'b10;
      logic [31:0] addr   = 32'h600 + 32'($urandom_range(0, 15));
      logic [31:0] wdata  = $urandom;
      do_access(is_mem, we, len, addr, wdata, is_mem ? (we ? "rand_store" : "rand_load") : "rand_fetch");
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_if_fetch();
    test_simultaneous();
    test_store_half();
    test_wrap();
    test_hold_through_done();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
